// File: rtl/fxp_div_root_if.sv
// Request/response bundle for fxp_div_root. The master issues operands and
// consumes results; the slave is the arithmetic block.
interface fxp_div_root_if #(
  parameter int INT_W  = 10,
  parameter int FRAC_W = 10,
  parameter int ARG_W  = 3
);
  localparam int W = INT_W + FRAC_W;

  logic             in_valid;
  logic             in_ready;
  logic             in_mode;
  logic [INT_W-1:0] in_data_1;
  logic [ARG_W-1:0] in_data_2;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic             out_err;

  modport master (
    output in_valid, in_mode, in_data_1, in_data_2, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );

  modport slave (
    input  in_valid, in_mode, in_data_1, in_data_2, out_ready,
    output in_ready, out_valid, out_data, out_err
  );
endinterface

// File: rtl/fxp_div_root.sv
// Sequential unsigned fixed-point divider / n-th root: restoring division one
// quotient bit per cycle, or bitwise root search using repeated fixed-point multiplies.
module fxp_div_root #(
  parameter int INT_W  = 10,
  parameter int FRAC_W = 10,
  parameter int ARG_W  = 3
) (
  input  logic clk,
  input  logic rst_n,
  fxp_div_root_if.slave bus
);
  localparam int W     = INT_W + FRAC_W;
  localparam int BIT_W = $clog2(W);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_ROOT, S_DONE} state_e;

  state_e state_q, state_d;

  logic [INT_W-1:0] x_q,    x_d;
  logic [ARG_W-1:0] arg_q,  arg_d;
  logic [W-1:0]     acc_q,  acc_d;   // dividend/quotient shift reg, or root Q
  logic [ARG_W-1:0] rem_q,  rem_d;
  logic [W-1:0]     p_q,    p_d;
  logic             over_q, over_d;
  logic             err_q,  err_d;
  logic [BIT_W-1:0] bit_q,  bit_d;
  logic [ARG_W-1:0] mul_q,  mul_d;

  logic             accept;
  logic             last_bit;
  logic             cmp_cycle;
  logic [W-1:0]     mask;
  logic [W-1:0]     t_val;
  logic [W-1:0]     x_ext;
  logic [2*W-1:0]   prod_sh;
  logic [ARG_W:0]   rem_sh;
  logic [ARG_W-1:0] rem_sub;
  logic             keep;
  logic [W-1:0]     acc_new;

  assign accept    = (state_q == S_IDLE) && bus.in_valid;
  assign last_bit  = (bit_q == '0);
  assign cmp_cycle = (mul_q == '0);
  assign mask      = W'(1) << bit_q;
  assign t_val     = acc_q | mask;
  assign x_ext     = {x_q, {FRAC_W{1'b0}}};
  // Scaled product; any set bit above W means the power overflowed the format.
  assign prod_sh   = ({{W{1'b0}}, p_q} * {{W{1'b0}}, t_val}) >> FRAC_W;
  assign rem_sh    = {rem_q, acc_q[W-1]};
  assign rem_sub   = rem_sh[ARG_W-1:0] - arg_q;
  assign keep      = !over_q && (p_q <= x_ext);
  assign acc_new   = keep ? t_val : acc_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (bus.in_valid) begin
        if (bus.in_data_2 == '0) state_d = S_DONE;
        else                     state_d = bus.in_mode ? S_ROOT : S_DIV;
      end
      S_DIV:  if (last_bit) state_d = S_DONE;
      S_ROOT: if (last_bit && cmp_cycle) state_d = S_DONE;
      S_DONE: if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == S_IDLE);
    bus.out_valid = (state_q == S_DONE);
    bus.out_data  = (state_q == S_DONE) ? acc_q : '0;
    bus.out_err   = (state_q == S_DONE) && err_q;
  end

  // NOTE: every next-state signal takes a default first, so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    x_d    = x_q;
    arg_d  = arg_q;
    acc_d  = acc_q;
    rem_d  = rem_q;
    p_d    = p_q;
    over_d = over_q;
    err_d  = err_q;
    bit_d  = bit_q;
    mul_d  = mul_q;
    unique case (state_q)
      S_IDLE: if (accept) begin
        x_d    = bus.in_data_1;
        arg_d  = bus.in_data_2;
        rem_d  = '0;
        over_d = 1'b0;
        bit_d  = BIT_W'(W - 1);
        mul_d  = bus.in_data_2 - ARG_W'(1);
        p_d    = W'(1) << (W - 1);
        if (bus.in_data_2 == '0) begin
          err_d = 1'b1;
          acc_d = '1;
        end else begin
          err_d = 1'b0;
          acc_d = bus.in_mode ? '0 : {bus.in_data_1, {FRAC_W{1'b0}}};
        end
      end
      S_DIV: begin
        if (rem_sh >= {1'b0, arg_q}) begin
          rem_d = rem_sub;
          acc_d = {acc_q[W-2:0], 1'b1};
        end else begin
          rem_d = rem_sh[ARG_W-1:0];
          acc_d = {acc_q[W-2:0], 1'b0};
        end
        if (!last_bit) bit_d = bit_q - BIT_W'(1);
      end
      S_ROOT: begin
        if (!cmp_cycle) begin
          p_d    = prod_sh[W-1:0];
          over_d = over_q | (|prod_sh[2*W-1:W]);
          mul_d  = mul_q - ARG_W'(1);
        end else begin
          acc_d  = acc_new;
          over_d = 1'b0;
          mul_d  = arg_q - ARG_W'(1);
          p_d    = acc_new | (mask >> 1);
          if (!last_bit) bit_d = bit_q - BIT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q    <= '0;
      arg_q  <= '0;
      acc_q  <= '0;
      rem_q  <= '0;
      p_q    <= '0;
      over_q <= 1'b0;
      err_q  <= 1'b0;
      bit_q  <= '0;
      mul_q  <= '0;
    end else begin
      x_q    <= x_d;
      arg_q  <= arg_d;
      acc_q  <= acc_d;
      rem_q  <= rem_d;
      p_q    <= p_d;
      over_q <= over_d;
      err_q  <= err_d;
      bit_q  <= bit_d;
      mul_q  <= mul_d;
    end
  end
endmodule

// File: tb/tb_fxp_div_root.sv
// Directed plus random bench for fxp_div_root; expected results and latencies
// are queued at acceptance and compared when out_valid appears.
module tb_fxp_div_root;
  localparam int INT_W  = 10;
  localparam int FRAC_W = 10;
  localparam int ARG_W  = 3;
  localparam int W      = INT_W + FRAC_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fxp_div_root_if #(.INT_W(INT_W), .FRAC_W(FRAC_W), .ARG_W(ARG_W)) bus ();

  fxp_div_root #(.INT_W(INT_W), .FRAC_W(FRAC_W), .ARG_W(ARG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [W-1:0] data;
    logic         err;
    int           lat;
    int           acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] model_div(input int x, input int d);
    logic [2*W-1:0] num;
    num = 40'(x) << FRAC_W;
    return W'(num / 40'(d));
  endfunction

  function automatic logic [W-1:0] model_root(input int x, input int n);
    logic [W-1:0]   q, t, p, lim;
    logic [2*W-1:0] prod;
    logic           over;
    q   = '0;
    lim = W'(x) << FRAC_W;
    for (int i = W - 1; i >= 0; i--) begin
      t    = q | (W'(1) << i);
      p    = t;
      over = 1'b0;
      for (int k = 1; k < n; k++) begin
        prod = ({{W{1'b0}}, p} * {{W{1'b0}}, t}) >> FRAC_W;
        if (prod >= (40'(1) << W)) over = 1'b1;
        p = prod[W-1:0];
      end
      if (!over && p <= lim) q = t;
    end
    return q;
  endfunction

  function automatic int model_lat(input bit mode, input int a);
    if (a == 0) return 1;
    return mode ? W * a + 1 : W + 1;
  endfunction

  task automatic send(input bit mode, input int x, input int a,
                      input logic [W-1:0] exp_data, input bit push);
    exp_t e;
    int   waited;
    bus.in_valid  = 1'b1;
    bus.in_mode   = mode;
    bus.in_data_1 = INT_W'(x);
    bus.in_data_2 = ARG_W'(a);
    waited = 0;
    while (!bus.in_ready && waited < 2000) begin
      tick();
      waited++;
    end
    if (!bus.in_ready) check("send_timeout_in_ready", 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_valid = 1'b0;
    e.data    = exp_data;
    e.err     = (a == 0);
    e.lat     = model_lat(mode, a);
    e.acc_cyc = cyc;
    if (push) sb.push_back(e);
  endtask

  task automatic collect(input string tag, input int budget);
    exp_t e;
    int   n;
    n = 0;
    while (!bus.out_valid && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    if (bus.out_valid && sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_data"}, 64'(bus.out_data), 64'(e.data));
      check({tag, "_err"},  64'(bus.out_err),  64'(e.err));
      check({tag, "_lat"},  64'(cyc - e.acc_cyc + 1), 64'(e.lat));
    end
    if (bus.out_ready) begin
      tick();
      check({tag, "_valid_drop"}, 64'(bus.out_valid), 64'd0);
      check({tag, "_data_zero"},  64'(bus.out_data),  64'd0);
      check({tag, "_err_zero"},   64'(bus.out_err),   64'd0);
    end
  endtask

  initial begin
    logic [W-1:0] held;
    logic [W-1:0] exp_r;
    exp_t         e2;
    bit           mode;
    int           x, a;
    bit           seen;

    bus.in_valid  = 1'b0;
    bus.in_mode   = 1'b0;
    bus.in_data_1 = '0;
    bus.in_data_2 = '0;
    bus.out_ready = 1'b1;

    repeat (3) tick();
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data",  64'(bus.out_data),  64'd0);
    check("rst_out_err",   64'(bus.out_err),   64'd0);
    rst_n = 1'b1;
    check("rst_in_ready",  64'(bus.in_ready),  64'd1);

    send(1'b0, 1000, 3, 20'h53555, 1'b1);  collect("div_1000_3", 200);
    send(1'b1, 1000, 3, 20'h02800, 1'b1);  collect("root_1000_3", 200);
    send(1'b1, 1023, 1, 20'hFFC00, 1'b1);  collect("root_1023_1", 200);
    send(1'b0, 7, 0,    20'hFFFFF, 1'b1);  collect("div_by_zero", 20);
    send(1'b1, 5, 0,    20'hFFFFF, 1'b1);  collect("root_n_zero", 20);
    send(1'b0, 1023, 1, 20'hFFC00, 1'b1);  collect("div_1023_1", 200);
    send(1'b0, 0, 5,    20'h00000, 1'b1);  collect("div_0_5", 200);
    send(1'b1, 1023, 7, model_root(1023, 7), 1'b1); collect("root_1023_7", 400);

    // Result held in DONE while the next request waits on in_valid.
    bus.out_ready = 1'b0;
    send(1'b0, 1000, 3, 20'h53555, 1'b1);
    bus.in_valid  = 1'b1;
    bus.in_mode   = 1'b1;
    bus.in_data_1 = INT_W'(8);
    bus.in_data_2 = ARG_W'(3);
    collect("hold_first", 200);
    held = bus.out_data;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_valid",    64'(bus.out_valid), 64'd1);
      check("hold_data",     64'(bus.out_data),  64'(held));
      check("hold_in_ready", 64'(bus.in_ready),  64'd0);
    end
    bus.out_ready = 1'b1;
    tick();
    check("handshake_valid_drop", 64'(bus.out_valid), 64'd0);
    check("handshake_in_ready",   64'(bus.in_ready),  64'd1);
    tick();
    bus.in_valid = 1'b0;
    check("second_accepted", 64'(bus.in_ready), 64'd0);
    e2.data = 20'h00800; e2.err = 1'b0; e2.lat = W * 3 + 1; e2.acc_cyc = cyc;
    sb.push_back(e2);
    collect("hold_second", 200);

    // Reset in the middle of a long root operation.
    send(1'b1, 512, 7, '0, 1'b0);
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_out_data",  64'(bus.out_data),  64'd0);
    check("midrst_out_err",   64'(bus.out_err),   64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (bus.out_valid) seen = 1'b1;
    end
    check("no_valid_after_reset", 64'(seen), 64'd0);
    send(1'b1, 8, 3, 20'h00800, 1'b1);  collect("post_reset_root", 200);

    for (int i = 0; i < 200; i++) begin
      mode  = 1'($urandom_range(0, 1));
      x     = $urandom_range(0, 1023);
      a     = $urandom_range(1, 7);
      exp_r = mode ? model_root(x, a) : model_div(x, a);
      send(mode, x, a, exp_r, 1'b1);
      collect("rand", 400);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fxp_div_root.md
FXP_DIV_ROOT -- requirements
Module: fxp_div_root

Interface
REQ-001 Parameter INT_W, default 10, integer width of in_data_1 and of the result integer part.
REQ-002 Parameter FRAC_W, default 10, fractional bits of the result; W = INT_W+FRAC_W.
REQ-003 Parameter ARG_W, default 3, width of in_data_2 (divisor / root index).
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  request present.
REQ-007 in_ready  output  1  block can accept a request.
REQ-008 in_mode  input  1  0 = division, 1 = n-th root.
REQ-009 in_data_1  input  INT_W  unsigned integer operand x.
REQ-010 in_data_2  input  ARG_W  unsigned divisor d (mode 0) or root index n (mode 1).
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  consumer takes result.
REQ-013 out_data  output  W  unsigned fixed-point result, INT_W.FRAC_W.
REQ-014 out_err  output  1  illegal operand (d=0 or n=0), qualified by out_valid.

Function
REQ-015 States IDLE, DIV, ROOT, DONE; in_ready=1 only in IDLE.
REQ-016 Acceptance on rising edge with in_valid&in_ready; mode and operands registered; inputs otherwise ignored.
REQ-017 Accept with d=0 (mode 0) or n=0 (mode 1): next state DONE, out_err=1, out_data=all ones.
REQ-018 Mode 0 result = floor(x*2^FRAC_W/d), restoring division over dividend {x, FRAC_W zeros}, MSB first, one quotient bit per cycle, W cycles in DIV.
REQ-019 Mode 1 result Q built MSB first over bits i=W-1..0; per bit: trial T=Q|2^i, p=T, then n-1 multiply cycles each p=floor(p*T/2^FRAC_W) with 2W-bit product.
REQ-020 Any product >= 2^W sets sticky over flag for that bit; remaining multiplies for that bit still consume cycles; p value is don't-care once over.
REQ-021 Compare cycle after multiplies: bit i kept iff !over and p <= {x, FRAC_W zeros}; over cleared for next bit.
REQ-022 Mode 1 per-bit cost = n cycles (n-1 multiply + 1 compare); n=1 gives 1 cycle/bit and Q = x<<FRAC_W.
REQ-023 Latency (acceptance edge to first out_valid=1 cycle): mode 0 = W+1 cycles, mode 1 = W*n+1 cycles, error = 1 cycle.
REQ-024 DONE: out_valid=1, out_data/out_err stable until out_valid&out_ready edge, then IDLE.
REQ-025 out_ready ignored outside DONE; no new request accepted in the DONE->IDLE handshake cycle (in_ready=0 there).
REQ-026 out_data and out_err zero whenever out_valid=0.
REQ-027 Iteration counter width ceil(log2(W))+ARG_W minimum; no wrap before final bit.

Reset
REQ-028 rst_n=0 asynchronously forces IDLE, in_ready=1 after release, out_valid=0, out_data=0, out_err=0, all datapath registers 0.
REQ-029 Reset mid-DIV/ROOT/DONE discards the operation; no result emitted after release.
REQ-030 First acceptance possible on first rising edge with rst_n=1.

Verification (defaults INT_W=10, FRAC_W=10, ARG_W=3)
REQ-031 mode0 x=1000 d=3, out_ready=1 -> out_data=0x53555 (341333), out_err=0, out_valid 21 cycles after acceptance, high 1 cycle.
REQ-032 mode1 x=1000 n=3 -> out_data=0x02800 (10.0), latency 61 cycles; mode1 x=1023 n=1 -> out_data=0xFFC00, latency 21.
REQ-033 mode0 x=7 d=0 and mode1 x=5 n=0 -> out_err=1, out_data=0xFFFFF, latency 1 cycle.
REQ-034 out_ready held low 5 cycles in DONE, in_valid held high throughout -> out_valid/out_data stable, in_ready=0, second request accepted only after handshake.
REQ-035 rst_n pulsed low 10 cycles into mode1 x=512 n=7 -> all outputs 0 immediately, no out_valid after release, next request x=8 n=3 -> 0x00800.
REQ-036 200 random requests (mode, x, d/n in 1..7) checked bit-exact against REQ-018..REQ-022 reference model, latency per REQ-023.
